// File: rtl/group_max_forward_if.sv
// Element stream into and out of the group-max forwarding delay line.
// master: producer/consumer side; slave: the delay line itself.
interface group_max_forward_if #(
    parameter int DATA_W    = 16,
    parameter int PAYLOAD_W = 16
);
    logic                 i_valid;
    logic                 i_last;
    logic [DATA_W-1:0]    i_loc_max;
    logic [PAYLOAD_W-1:0] i_payload;
    logic                 o_valid;
    logic                 o_last;
    logic [DATA_W-1:0]    o_global_max;
    logic [PAYLOAD_W-1:0] o_payload;
    logic                 o_overrun;

    modport master (
        output i_valid, i_last, i_loc_max, i_payload,
        input  o_valid, o_last, o_global_max, o_payload, o_overrun
    );

    modport slave (
        input  i_valid, i_last, i_loc_max, i_payload,
        output o_valid, o_last, o_global_max, o_payload, o_overrun
    );
endinterface

// File: rtl/group_max_forward.sv
// Group-max forwarding delay line: each element leaves LATENCY enabled
// cycles after entry, carrying the max over its i_last-delimited group.
// Ports: i_clk, i_rst (sync, active high), i_en (global stall),
//        bus (slave): i_valid/i_last/i_loc_max/i_payload in,
//        o_valid/o_last/o_global_max/o_payload/o_overrun out.
module group_max_forward #(
    parameter int DATA_W    = 16,
    parameter int PAYLOAD_W = 16,
    parameter int LATENCY   = 12,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    group_max_forward_if.slave  bus
);
    localparam int L = LATENCY;

    localparam logic [DATA_W-1:0] FLOOR =
        SIGNED ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

    logic [L-1:0]         valid_q, valid_d;
    logic [L-1:0]         last_q,  last_d;
    logic [L-1:0]         pend_q,  pend_d;
    logic [DATA_W-1:0]    max_q [L];
    logic [DATA_W-1:0]    max_d [L];
    logic [PAYLOAD_W-1:0] pay_q [L];
    logic [PAYLOAD_W-1:0] pay_d [L];
    logic [DATA_W-1:0]    acc_q,   acc_d;
    logic [DATA_W-1:0]    front;
    logic                 close;

    function automatic logic gt(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        if (SIGNED)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    always_comb begin
        front = gt(bus.i_loc_max, acc_q) ? bus.i_loc_max : acc_q;
        close = bus.i_valid & bus.i_last;

        acc_d = acc_q;
        if (bus.i_valid)
            acc_d = bus.i_last ? FLOOR : front;

        valid_d[0] = bus.i_valid;
        last_d[0]  = close;
        pend_d[0]  = bus.i_valid & ~bus.i_last;
        max_d[0]   = bus.i_valid ? front : FLOOR;
        pay_d[0]   = bus.i_valid ? bus.i_payload : '0;

        // Open-group entries track the running max as they shift;
        // a close loads the final max into all of them at once.
        // The entry leaving stage L-1 is never touched.
        for (int k = 1; k < L; k++) begin
            valid_d[k] = valid_q[k-1];
            last_d[k]  = last_q[k-1];
            pend_d[k]  = pend_q[k-1] & ~close;
            max_d[k]   = (pend_q[k-1] & bus.i_valid)
                       ? front : max_q[k-1];
            pay_d[k]   = pay_q[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            last_q  <= '0;
            pend_q  <= '0;
            acc_q   <= FLOOR;
            for (int k = 0; k < L; k++) begin
                max_q[k] <= FLOOR;
                pay_q[k] <= '0;
            end
        end else if (i_en) begin
            valid_q <= valid_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            for (int k = 0; k < L; k++) begin
                max_q[k] <= max_d[k];
                pay_q[k] <= pay_d[k];
            end
        end
    end

    assign bus.o_valid      = valid_q[L-1];
    assign bus.o_last       = last_q[L-1];
    assign bus.o_global_max = max_q[L-1];
    assign bus.o_payload    = pay_q[L-1];
    assign bus.o_overrun    = valid_q[L-1] & pend_q[L-1];
endmodule

// File: tb/tb_group_max_forward.sv
// Scoreboard bench for group_max_forward: signed and unsigned
// instances, directed groups with hand-computed maxima.
module tb_group_max_forward;
    localparam int LAT = 12;

    typedef struct {
        logic        last;
        logic [15:0] mx;
        logic [15:0] pay;
        logic        ovr;
        int          t;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    logic en  = 1;
    int   ecnt = 0;
    int   nchk = 0;
    int   nerr = 0;
    logic [15:0] pc = 16'h0100;

    exp_t qs[$];
    exp_t qu[$];

    group_max_forward_if #(16, 16) bs ();
    group_max_forward_if #(16, 16) bu ();

    group_max_forward #(
        .DATA_W(16), .PAYLOAD_W(16),
        .LATENCY(LAT), .SIGNED(1'b1)
    ) u_s (
        .i_clk(clk), .i_rst(rst),
        .i_en(en), .bus(bs)
    );

    group_max_forward #(
        .DATA_W(16), .PAYLOAD_W(16),
        .LATENCY(LAT), .SIGNED(1'b0)
    ) u_u (
        .i_clk(clk), .i_rst(rst),
        .i_en(en), .bus(bu)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (en) ecnt <= ecnt + 1;

    task automatic chk(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] req
    );
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    task automatic cmp(
        input string nm,
        input logic l, input logic [15:0] m,
        input logic [15:0] p, input logic o,
        input exp_t e
    );
        nchk++;
        if (l !== e.last || m !== e.mx || p !== e.pay ||
            o !== e.ovr || ecnt != e.t + LAT) begin
            nerr++;
            $display("FAIL %s got l=%b max=%h pay=%h ovr=%b t=%0d want l=%b max=%h pay=%h ovr=%b t=%0d",
                     nm, l, m, p, o, ecnt,
                     e.last, e.mx, e.pay, e.ovr, e.t + LAT);
        end
    endtask

    always @(negedge clk) begin
        if (en && !rst && bs.o_valid) begin
            if (qs.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL sgn_extra got pay=%h want none",
                         bs.o_payload);
            end else begin
                cmp("sgn_out", bs.o_last, bs.o_global_max,
                    bs.o_payload, bs.o_overrun, qs.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (en && !rst && bu.o_valid) begin
            if (qu.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL uns_extra got pay=%h want none",
                         bu.o_payload);
            end else begin
                cmp("uns_out", bu.o_last, bu.o_global_max,
                    bu.o_payload, bu.o_overrun, qu.pop_front());
            end
        end
    end

    task automatic idle_in();
        bs.i_valid = 0; bs.i_last = 0;
        bs.i_loc_max = 0; bs.i_payload = 0;
        bu.i_valid = 0; bu.i_last = 0;
        bu.i_loc_max = 0; bu.i_payload = 0;
    endtask

    // one input cycle; xm/xo are the hand-computed output fields
    task automatic elem(
        input bit u, input bit v, input bit last,
        input logic [15:0] loc,
        input logic [15:0] xm, input bit xo,
        input bit push
    );
        exp_t e;
        idle_in();
        if (v) begin
            if (u) begin
                bu.i_valid = 1; bu.i_last = last;
                bu.i_loc_max = loc; bu.i_payload = pc;
            end else begin
                bs.i_valid = 1; bs.i_last = last;
                bs.i_loc_max = loc; bs.i_payload = pc;
            end
            e.last = last; e.mx = xm; e.pay = pc;
            e.ovr = xo; e.t = ecnt;
            if (push) begin
                if (u) qu.push_back(e);
                else   qs.push_back(e);
            end
            pc = pc + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic bub();
        elem(0, 0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        idle_in();
        while ((qs.size() != 0 || qu.size() != 0) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        nchk++;
        if (qs.size() != 0 || qu.size() != 0) begin
            nerr++;
            $display("FAIL drain left %0d/%0d want 0",
                     qs.size(), qu.size());
            qs.delete(); qu.delete();
        end
    endtask

    task automatic chk_idle(input bit u, input logic [15:0] fl);
        if (u) begin
            chk("uns_rst_valid", bu.o_valid, 0);
            chk("uns_rst_last", bu.o_last, 0);
            chk("uns_rst_ovr", bu.o_overrun, 0);
            chk("uns_rst_pay", bu.o_payload, 0);
            chk("uns_rst_max", bu.o_global_max, fl);
        end else begin
            chk("sgn_rst_valid", bs.o_valid, 0);
            chk("sgn_rst_last", bs.o_last, 0);
            chk("sgn_rst_ovr", bs.o_overrun, 0);
            chk("sgn_rst_pay", bs.o_payload, 0);
            chk("sgn_rst_max", bs.o_global_max, fl);
        end
    endtask

    initial begin
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk_idle(0, 16'h8000);
        chk_idle(1, 16'h0000);

        // group 3,-5,9,1 -> 9
        elem(0, 1, 0, 16'd3,    16'd9, 0, 1);
        elem(0, 1, 0, 16'hFFFB, 16'd9, 0, 1);
        elem(0, 1, 0, 16'd9,    16'd9, 0, 1);
        elem(0, 1, 1, 16'd1,    16'd9, 0, 1);
        drain();

        // -7,_,_,-2,_,-9(last) -> -2
        elem(0, 1, 0, 16'hFFF9, 16'hFFFE, 0, 1);
        bub(); bub();
        elem(0, 1, 0, 16'hFFFE, 16'hFFFE, 0, 1);
        bub();
        elem(0, 1, 1, 16'hFFF7, 16'hFFFE, 0, 1);
        drain();

        // singles 5, 0x8000, -1
        elem(0, 1, 1, 16'd5,    16'd5,    0, 1);
        elem(0, 1, 1, 16'h8000, 16'h8000, 0, 1);
        elem(0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 1);
        drain();

        // 14-element group 0..13: overrun on first two
        for (int i = 0; i < 14; i++)
            elem(0, 1, i == 13, 16'(i),
                 i == 0 ? 16'd11 : (i == 1 ? 16'd12 : 16'd13),
                 i < 2, 1);
        drain();

        // 2, stall 5 cycles with junk, 8, 4(last) -> 8
        elem(0, 1, 0, 16'd2, 16'd8, 0, 1);
        en = 0;
        bs.i_valid = 1; bs.i_last = 1;
        bs.i_loc_max = 16'd100; bs.i_payload = 16'hDEAD;
        repeat (5) begin @(posedge clk); #1; end
        en = 1;
        elem(0, 1, 0, 16'd8, 16'd8, 0, 1);
        elem(0, 1, 1, 16'd4, 16'd8, 0, 1);
        drain();

        // reset discards an open group 7,20
        elem(0, 1, 0, 16'd7,  16'd0, 0, 0);
        elem(0, 1, 0, 16'd20, 16'd0, 0, 0);
        idle_in();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_idle(0, 16'h8000);
        elem(0, 1, 0, 16'd1, 16'd2, 0, 1);
        elem(0, 1, 1, 16'd2, 16'd2, 0, 1);
        drain();

        // unsigned: 3,0xFFFF,9,1 -> 0xFFFF
        elem(1, 1, 0, 16'd3,    16'hFFFF, 0, 1);
        elem(1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 1);
        elem(1, 1, 0, 16'd9,    16'hFFFF, 0, 1);
        elem(1, 1, 1, 16'd1,    16'hFFFF, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end
endmodule
